// File: rtl/actuator_power_scheduler.sv
// actuator_power_scheduler
//   Shares the actuator power rail among N_ACT loads (pump, heater, cooler, light,
//   dehumidifier). It limits how many loads are on at once and enforces minimum on
//   and off times. The heater and cooler are never on together. Every load drops
//   when a fault is raised.
//
// Ports
//   clk_i          system clock
//   rst_i          synchronous reset, active-high
//   ena_i          low freezes every register, including the prescaler and timers
//   req_i          level requests, bit i = actuator i (index 0 has the highest priority)
//   fault_in_i     level fault; while high, all grants are forced off and none are issued
//   grant_o        registered actuator enables
//   active_cnt_o   registered popcount of grant_o
//   pending_o      registered req & ~grant (requested but not powered)
//   tick_o         one-cycle strobe every TICK_DIV enabled cycles
module actuator_power_scheduler #(
    parameter int unsigned N_ACT         = 5,
    parameter int unsigned MAX_ON        = 2,
    parameter int unsigned TICK_DIV      = 25000,
    parameter int unsigned MIN_ON_TICKS  = 4,
    parameter int unsigned MIN_OFF_TICKS = 4,
    parameter int unsigned HEAT_IDX      = 1,
    parameter int unsigned COOL_IDX      = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ena_i,
    input  logic [N_ACT-1:0] req_i,
    input  logic             fault_in_i,
    output logic [N_ACT-1:0] grant_o,
    output logic [2:0]       active_cnt_o,
    output logic [N_ACT-1:0] pending_o,
    output logic             tick_o
);

    localparam int unsigned MaxTicks = (MIN_ON_TICKS > MIN_OFF_TICKS) ? MIN_ON_TICKS
                                                                      : MIN_OFF_TICKS;
    localparam int unsigned TimerW   = (MaxTicks < 1) ? 1 : $clog2(MaxTicks + 1);
    localparam int unsigned PrescW   = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
    localparam int unsigned CntW     = $clog2(N_ACT + 1);

    localparam logic [TimerW-1:0] OnLoad   = TimerW'(MIN_ON_TICKS);
    localparam logic [TimerW-1:0] OffLoad  = TimerW'(MIN_OFF_TICKS);
    localparam logic [TimerW-1:0] TimerOne = TimerW'(1);
    localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);
    localparam logic [CntW-1:0]   Cap      = CntW'(MAX_ON);

    typedef enum logic [1:0] {
        StOffIdle,
        StOnLock,
        StOnRun,
        StOffLock
    } act_state_e;

    act_state_e        state_q [N_ACT];
    act_state_e        state_d [N_ACT];
    logic [TimerW-1:0] timer_q [N_ACT];
    logic [TimerW-1:0] timer_d [N_ACT];

    logic [PrescW-1:0] presc_q, presc_d;
    logic [N_ACT-1:0]  grant_q, grant_d;
    logic [N_ACT-1:0]  pending_q, pending_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              tick;
    logic [N_ACT-1:0]  on_now;
    logic [N_ACT-1:0]  turn_off;
    logic [N_ACT-1:0]  cand;
    logic [N_ACT-1:0]  sel;
    logic [CntW-1:0]   keep_cnt;
    logic [CntW-1:0]   sel_cnt;
    logic              heat_cand;

    assign tick = (presc_q == PrescMax);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < N_ACT; i++) begin
                state_q[i] <= StOffIdle;
                timer_q[i] <= '0;
            end
            presc_q   <= '0;
            grant_q   <= '0;
            pending_q <= '0;
            cnt_q     <= '0;
        end else if (ena_i) begin
            for (int unsigned i = 0; i < N_ACT; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
            presc_q   <= presc_d;
            grant_q   <= grant_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next state: per-actuator timers and turn-offs, then the arbiter
    always_comb begin
        presc_d   = tick ? '0 : presc_q + 1'b1;
        on_now    = '0;
        turn_off  = '0;
        cand      = '0;
        sel       = '0;
        keep_cnt  = '0;
        sel_cnt   = '0;
        heat_cand = 1'b0;

        for (int unsigned i = 0; i < N_ACT; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            on_now[i]  = (state_q[i] == StOnLock) || (state_q[i] == StOnRun);

            case (state_q[i])
                StOnLock: begin
                    // Fault overrides the minimum on-time.
                    if (fault_in_i) begin
                        turn_off[i] = 1'b1;
                    end else if (tick) begin
                        if (timer_q[i] <= TimerOne) begin
                            state_d[i] = StOnRun;
                            timer_d[i] = '0;
                        end else begin
                            timer_d[i] = timer_q[i] - TimerOne;
                        end
                    end
                end
                StOnRun: begin
                    if (fault_in_i || !req_i[i]) begin
                        turn_off[i] = 1'b1;
                    end
                end
                StOffLock: begin
                    // Lockout keeps counting during a fault; requests are ignored.
                    if (tick) begin
                        if (timer_q[i] <= TimerOne) begin
                            state_d[i] = StOffIdle;
                            timer_d[i] = '0;
                        end else begin
                            timer_d[i] = timer_q[i] - TimerOne;
                        end
                    end
                end
                default: ;
            endcase

            if (turn_off[i]) begin
                if (MIN_OFF_TICKS == 0) begin
                    state_d[i] = StOffIdle;
                    timer_d[i] = '0;
                end else begin
                    state_d[i] = StOffLock;
                    timer_d[i] = OffLoad;
                end
            end
        end

        // Slots freed by this cycle's turn-offs are reusable immediately.
        for (int unsigned i = 0; i < N_ACT; i++) begin
            keep_cnt = keep_cnt + CntW'(on_now[i] & ~turn_off[i]);
        end

        heat_cand = (state_q[HEAT_IDX] == StOffIdle) && req_i[HEAT_IDX] && !fault_in_i;

        // Exclusion uses the pre-turn-off state, so the cooler waits one cycle
        // after the heater's grant drops (and vice versa).
        sel_cnt = keep_cnt;
        for (int unsigned i = 0; i < N_ACT; i++) begin
            cand[i] = (state_q[i] == StOffIdle) && req_i[i] && !fault_in_i;
            if (i == COOL_IDX && (on_now[HEAT_IDX] || heat_cand)) begin
                cand[i] = 1'b0;
            end
            if (i == HEAT_IDX && on_now[COOL_IDX]) begin
                cand[i] = 1'b0;
            end
            if (cand[i] && (sel_cnt < Cap)) begin
                sel[i]  = 1'b1;
                sel_cnt = sel_cnt + 1'b1;
                if (MIN_ON_TICKS == 0) begin
                    state_d[i] = StOnRun;
                    timer_d[i] = '0;
                end else begin
                    state_d[i] = StOnLock;
                    timer_d[i] = OnLoad;
                end
            end
        end
    end

    // Outputs: registered copies of the next-state decode
    always_comb begin
        grant_d = '0;
        cnt_d   = '0;
        for (int unsigned i = 0; i < N_ACT; i++) begin
            grant_d[i] = (state_d[i] == StOnLock) || (state_d[i] == StOnRun);
            cnt_d      = cnt_d + CntW'(grant_d[i]);
        end
        pending_d = req_i & ~grant_d;
    end

    assign grant_o      = grant_q;
    assign pending_o    = pending_q;
    assign active_cnt_o = 3'(cnt_q);
    assign tick_o       = tick;

endmodule

// File: tb/tb_actuator_power_scheduler.sv
// Table-driven bench for actuator_power_scheduler with TICK_DIV=4, MIN_ON_TICKS=3,
// MIN_OFF_TICKS=2, MAX_ON=2. Each vector holds its inputs for ncyc edges. The
// expectation is queued when the vector is driven and popped after the last edge.
module tb_actuator_power_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       fault;
    logic [4:0] req;
    logic [4:0] grant;
    logic [4:0] pending;
    logic [2:0] cnt;
    logic       tick;

    always #5 clk = ~clk;

    actuator_power_scheduler #(
        .N_ACT        (5),
        .MAX_ON       (2),
        .TICK_DIV     (4),
        .MIN_ON_TICKS (3),
        .MIN_OFF_TICKS(2),
        .HEAT_IDX     (1),
        .COOL_IDX     (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ena_i       (ena),
        .req_i       (req),
        .fault_in_i  (fault),
        .grant_o     (grant),
        .active_cnt_o(cnt),
        .pending_o   (pending),
        .tick_o      (tick)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic       ena;
        logic       fault;
        logic [4:0] req;
        int         ncyc;
        logic [4:0] g;
        logic [4:0] p;
        logic [2:0] c;
        logic       t;
    } vec_t;

    typedef struct {
        string      name;
        logic [4:0] g;
        logic [4:0] p;
        logic [2:0] c;
        logic       t;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    function automatic void add(input string n, input logic r, input logic e, input logic f,
                                input logic [4:0] q, input int nc, input logic [4:0] g,
                                input logic [4:0] p, input logic [2:0] c, input logic t);
        vec_t v;
        v.name = n; v.rst = r; v.ena = e; v.fault = f; v.req = q; v.ncyc = nc;
        v.g = g; v.p = p; v.c = c; v.t = t;
        vecs.push_back(v);
    endfunction

    // Invariants checked every cycle once the first reset has completed.
    always @(negedge clk) begin
        if (mon_en) begin
            cmp("inv_cnt", 32'(cnt), 32'($countones(grant)));
            cmp("inv_excl", 32'(grant[1] & grant[2]), 32'd0);
            cmp("inv_cap", 32'($countones(grant) <= 2), 32'd1);
        end
    end

    initial begin
        vec_t v;
        exp_t e;
        int   en_cnt;

        //   name           rst ena flt req       n   grant     pending   cnt tick
        add("reset",        1, 1, 0, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0);
        add("c1_lat",       0, 1, 0, 5'b00001, 1, 5'b00001, 5'b00000, 1, 0);
        add("c1_tick",      0, 1, 0, 5'b00001, 2, 5'b00001, 5'b00000, 1, 1);
        add("c1_hold_t1",   0, 1, 0, 5'b00001, 1, 5'b00001, 5'b00000, 1, 0);
        add("c1_hold_noreq",0, 1, 0, 5'b00000, 7, 5'b00001, 5'b00000, 1, 1);
        add("c1_hold_end",  0, 1, 0, 5'b00000, 1, 5'b00001, 5'b00000, 1, 0);
        add("c1_fall",      0, 1, 0, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0);
        add("c2_lock",      0, 1, 0, 5'b00001, 1, 5'b00000, 5'b00001, 0, 0);
        add("c2_lock_mid",  0, 1, 0, 5'b00001, 5, 5'b00000, 5'b00001, 0, 1);
        add("c2_lock_end",  0, 1, 0, 5'b00001, 1, 5'b00000, 5'b00001, 0, 0);
        add("c2_regrant",   0, 1, 0, 5'b00001, 1, 5'b00001, 5'b00000, 1, 0);
        add("c3_cap",       0, 1, 0, 5'b11001, 1, 5'b01001, 5'b10000, 2, 0);
        add("c3_hold",      0, 1, 0, 5'b11001, 9, 5'b01001, 5'b10000, 2, 1);
        add("c3_hold_end",  0, 1, 0, 5'b11001, 1, 5'b01001, 5'b10000, 2, 0);
        add("c3_swap",      0, 1, 0, 5'b11000, 1, 5'b11000, 5'b00000, 2, 0);
        add("c4_reset",     1, 1, 0, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0);
        add("c4_excl",      0, 1, 0, 5'b00110, 1, 5'b00010, 5'b00100, 1, 0);
        add("c4_hold",      0, 1, 0, 5'b00110,10, 5'b00010, 5'b00100, 1, 1);
        add("c4_hold_end",  0, 1, 0, 5'b00110, 1, 5'b00010, 5'b00100, 1, 0);
        add("c4_heat_off",  0, 1, 0, 5'b00100, 1, 5'b00000, 5'b00100, 0, 0);
        add("c4_cool_on",   0, 1, 0, 5'b00100, 1, 5'b00100, 5'b00000, 1, 0);
        add("c4_cool_hold", 0, 1, 0, 5'b00100, 6, 5'b00100, 5'b00000, 1, 0);
        add("c4_heat_blk",  0, 1, 0, 5'b00110, 1, 5'b00100, 5'b00010, 1, 0);
        add("c5_reset",     1, 1, 0, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0);
        add("c5_both",      0, 1, 0, 5'b01001, 1, 5'b01001, 5'b00000, 2, 0);
        add("c5_fault",     0, 1, 1, 5'b01001, 1, 5'b00000, 5'b01001, 0, 0);
        add("c5_lock",      0, 1, 0, 5'b01001, 5, 5'b00000, 5'b01001, 0, 1);
        add("c5_lock_end",  0, 1, 0, 5'b01001, 1, 5'b00000, 5'b01001, 0, 0);
        add("c5_regrant",   0, 1, 0, 5'b01001, 1, 5'b01001, 5'b00000, 2, 0);
        add("flt_reset",    1, 1, 0, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0);
        add("flt_block",    0, 1, 1, 5'b00001, 1, 5'b00000, 5'b00001, 0, 0);
        add("flt_clear",    0, 1, 0, 5'b00001, 1, 5'b00001, 5'b00000, 1, 0);
        add("cap_reset",    1, 1, 0, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0);
        add("cap_all",      0, 1, 0, 5'b11111, 1, 5'b00011, 5'b11100, 2, 0);
        add("c6_reset",     1, 1, 0, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0);
        add("c6_on",        0, 1, 0, 5'b00001, 1, 5'b00001, 5'b00000, 1, 0);
        add("c6_pre",       0, 1, 0, 5'b00001, 2, 5'b00001, 5'b00000, 1, 1);
        add("c6_freeze",    0, 0, 0, 5'b00000,20, 5'b00001, 5'b00000, 1, 1);
        add("c6_hold",      0, 1, 0, 5'b00000, 8, 5'b00001, 5'b00000, 1, 1);
        add("c6_hold_end",  0, 1, 0, 5'b00000, 1, 5'b00001, 5'b00000, 1, 0);
        add("c6_fall",      0, 1, 0, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0);
        add("c6_rst",       1, 1, 0, 5'b00001, 1, 5'b00000, 5'b00000, 0, 0);
        add("c6_after",     0, 1, 0, 5'b00001, 1, 5'b00001, 5'b00000, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            v     = vecs[i];
            rst   = v.rst;
            ena   = v.ena;
            fault = v.fault;
            req   = v.req;
            e.name = v.name; e.g = v.g; e.p = v.p; e.c = v.c; e.t = v.t;
            sb.push_back(e);
            repeat (v.ncyc) @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s scoreboard empty got 0 want 1", v.name);
            end else begin
                e = sb.pop_front();
                cmp({e.name, "_grant"},   32'(grant),   32'(e.g));
                cmp({e.name, "_pending"}, 32'(pending), 32'(e.p));
                cmp({e.name, "_cnt"},     32'(cnt),     32'(e.c));
                cmp({e.name, "_tick"},    32'(tick),    32'(e.t));
            end
            mon_en = 1'b1;
        end

        // Tick strobe counts only enabled cycles.
        rst = 1'b1; ena = 1'b1; fault = 1'b0; req = '0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        en_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            ena = (c % 3) != 2;
            @(posedge clk);
            #1;
            if (ena) en_cnt++;
            cmp("tick_seq", 32'(tick), 32'((en_cnt % 4) == 3));
        end
        cmp("tick_seq_grant", 32'(grant), 32'd0);
        ena = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
